// File: rtl/csr_obi_arbiter.sv
// csr_obi_arbiter: round-robin arbiter sharing one OBI CSR slave port among NHARTS data masters.
// One transaction outstanding at a time; a response timeout returns ERR_RDATA and flushes the late reply.
module csr_obi_arbiter #(
    parameter int NHARTS = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF,
    localparam int OW = NHARTS > 1 ? $clog2(NHARTS) : 1,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NHARTS-1:0]    master_req_i,
    input  logic [NHARTS-1:0]    master_we_i,
    input  logic [NHARTS*4-1:0]  master_be_i,
    input  logic [NHARTS*32-1:0] master_addr_i,
    input  logic [NHARTS*32-1:0] master_wdata_i,
    output logic [NHARTS-1:0]    master_gnt_o,
    output logic [NHARTS-1:0]    master_rvalid_o,
    output logic [NHARTS*32-1:0] master_rdata_o,
    output logic                 slave_req_o,
    output logic                 slave_we_o,
    output logic [3:0]           slave_be_o,
    output logic [31:0]          slave_addr_o,
    output logic [31:0]          slave_wdata_o,
    input  logic                 slave_gnt_i,
    input  logic                 slave_rvalid_i,
    input  logic [31:0]          slave_rdata_i,
    output logic [OW-1:0]        owner_o,
    output logic                 busy_o,
    output logic                 timeout_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, FLUSH} state_t;
    state_t state, state_nxt;
    logic [OW-1:0] owner, rr_ptr, pick;
    logic [CW-1:0] cnt;
    logic found, at_limit;
    assign at_limit = cnt == CW'(TIMEOUT_CYCLES);
    assign owner_o = rst_i ? '0 : owner;
    assign busy_o = !rst_i && state != IDLE;
    always_comb begin
        pick = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NHARTS; k++) begin
            if (!found && master_req_i[(int'(rr_ptr) + k) % NHARTS]) begin
                pick = OW'((int'(rr_ptr) + k) % NHARTS);
                found = 1'b1;
            end
        end
    end
    // Reset forces the IDLE decode so every output is quiet while rst_i is high.
    always_comb begin
        state_nxt = state;
        slave_req_o = 1'b0;
        slave_we_o = 1'b0;
        slave_be_o = '0;
        slave_addr_o = '0;
        slave_wdata_o = '0;
        master_gnt_o = '0;
        master_rvalid_o = '0;
        master_rdata_o = '0;
        timeout_o = 1'b0;
        case (rst_i ? IDLE : state)
            IDLE: state_nxt = found ? REQ : IDLE;
            REQ: begin
                slave_req_o = master_req_i[owner];
                slave_we_o = master_we_i[owner];
                slave_be_o = master_be_i[owner*4 +: 4];
                slave_addr_o = master_addr_i[owner*32 +: 32];
                slave_wdata_o = master_wdata_i[owner*32 +: 32];
                master_gnt_o[owner] = slave_gnt_i;
                state_nxt = slave_gnt_i ? RESP : !master_req_i[owner] ? IDLE : REQ;
            end
            RESP: begin
                if (slave_rvalid_i) begin
                    master_rvalid_o[owner] = 1'b1;
                    master_rdata_o[owner*32 +: 32] = slave_rdata_i;
                    state_nxt = IDLE;
                end else if (at_limit) begin
                    master_rvalid_o[owner] = 1'b1;
                    master_rdata_o[owner*32 +: 32] = ERR_RDATA;
                    timeout_o = 1'b1;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: state_nxt = slave_rvalid_i ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found)
                owner <= pick;
            if (state == REQ && slave_gnt_i) begin
                rr_ptr <= owner == OW'(NHARTS - 1) ? '0 : owner + 1'b1;
                cnt <= '0;
            end else if (state == RESP && !at_limit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_csr_obi_arbiter.sv
// tb_csr_obi_arbiter: scoreboard bench for csr_obi_arbiter with TIMEOUT_CYCLES=4.
module tb_csr_obi_arbiter;
    localparam int N = 3;
    localparam logic [31:0] K = 32'h5A5A_0000;
    logic clk_i = 1'b0;
    logic rst_i;
    logic [N-1:0] master_req_i, master_we_i, master_gnt_o, master_rvalid_o;
    logic [N*4-1:0] master_be_i;
    logic [N*32-1:0] master_addr_i, master_wdata_i, master_rdata_o;
    logic slave_req_o, slave_we_o, slave_gnt_i, slave_rvalid_i;
    logic [3:0] slave_be_o;
    logic [31:0] slave_addr_o, slave_wdata_o, slave_rdata_i;
    logic [1:0] owner_o;
    logic busy_o, timeout_o;
    logic auto, man_gnt, man_rvalid;
    logic pend = 1'b0;
    logic [31:0] man_rdata, prd;
    int vectors = 0, miscompares = 0;
    typedef struct {int hart; logic [31:0] rdata; logic to;} rv_t;
    int gnt_q[$];
    rv_t rv_q[$];
    rv_t e;
    int g;

    always #5 clk_i = ~clk_i;

    csr_obi_arbiter #(.NHARTS(N), .TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .master_req_i(master_req_i), .master_we_i(master_we_i), .master_be_i(master_be_i),
        .master_addr_i(master_addr_i), .master_wdata_i(master_wdata_i),
        .master_gnt_o(master_gnt_o), .master_rvalid_o(master_rvalid_o), .master_rdata_o(master_rdata_o),
        .slave_req_o(slave_req_o), .slave_we_o(slave_we_o), .slave_be_o(slave_be_o),
        .slave_addr_o(slave_addr_o), .slave_wdata_o(slave_wdata_o),
        .slave_gnt_i(slave_gnt_i), .slave_rvalid_i(slave_rvalid_i), .slave_rdata_i(slave_rdata_i),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    // Auto slave: grants immediately, answers one cycle later with addr ^ K.
    assign slave_gnt_i = auto ? slave_req_o : man_gnt;
    assign slave_rvalid_i = auto ? pend : man_rvalid;
    assign slave_rdata_i = auto ? prd : man_rdata;
    always @(posedge clk_i) begin
        pend <= auto && slave_req_o && slave_gnt_i;
        prd <= slave_addr_o ^ K;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_rv(input int h, input logic [31:0] d, input logic t);
        rv_t x;
        x.hart = h;
        x.rdata = d;
        x.to = t;
        rv_q.push_back(x);
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (gnt_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        if (gnt_q.size() != 0) check("gnt_wait", gnt_q.size(), 0);
        gnt_q.delete();
    endtask

    task automatic wait_rv();
        int n = 0;
        while (rv_q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        if (rv_q.size() != 0) check("rv_wait", rv_q.size(), 0);
        rv_q.delete();
    endtask

    always @(negedge clk_i) begin
        if (|master_gnt_o) begin
            if (gnt_q.size() == 0) check("gnt_unexp", master_gnt_o, 0);
            else begin
                g = gnt_q.pop_front();
                check("gnt_hart", master_gnt_o, 32'(1) << g);
            end
        end
        if (|master_rvalid_o) begin
            if (rv_q.size() == 0) check("rv_unexp", master_rvalid_o, 0);
            else begin
                e = rv_q.pop_front();
                check("rv_vec", master_rvalid_o, 32'(1) << e.hart);
                check("rv_data", master_rdata_o[e.hart*32 +: 32], e.rdata);
                check("rv_to", timeout_o, e.to);
            end
        end else if (timeout_o || |master_rdata_o) begin
            check("quiet_out", {timeout_o, |master_rdata_o}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        auto = 1'b1;
        man_gnt = 1'b0;
        man_rvalid = 1'b0;
        man_rdata = '0;
        master_req_i = 3'b111;
        master_we_i = '0;
        master_be_i = '1;
        for (int i = 0; i < N; i++) begin
            master_addr_i[i*32 +: 32] = 32'h100 + 32'(4 * i);
            master_wdata_i[i*32 +: 32] = 32'hA000 + 32'(i);
        end
        for (int i = 0; i < 6; i++) begin
            gnt_q.push_back(i % 3);
            push_rv(i % 3, (32'h100 + 32'(4 * (i % 3))) ^ K, 1'b0);
        end
        repeat (2) @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_to", timeout_o, 0);
        check("rst_sreq", slave_req_o, 0);
        check("rst_gnt", master_gnt_o, 0);
        check("rst_rv", master_rvalid_o, 0);
        check("rst_rdata", master_rdata_o[31:0] | master_rdata_o[63:32] | master_rdata_o[95:64], 0);
        cyc();
        rst_i = 1'b0;
        wait_gnt();
        master_req_i = '0;
        wait_rv();
        // single write from hart1, slave grants on the second REQ cycle
        auto = 1'b0;
        master_req_i = 3'b010;
        master_we_i = 3'b010;
        master_addr_i[63:32] = 32'h10;
        cyc();
        @(negedge clk_i);
        check("wr_sreq", slave_req_o, 1);
        check("wr_addr", slave_addr_o, 32'h10);
        check("wr_we", slave_we_o, 1);
        check("wr_owner", owner_o, 1);
        check("wr_nognt", master_gnt_o, 0);
        cyc();
        man_gnt = 1'b1;
        gnt_q.push_back(1);
        cyc();
        master_req_i = '0;
        master_we_i = '0;
        man_gnt = 1'b0;
        man_rvalid = 1'b1;
        man_rdata = 32'h1234_5678;
        push_rv(1, 32'h1234_5678, 1'b0);
        @(negedge clk_i);
        check("wr_busy_resp", busy_o, 1);
        cyc();
        man_rvalid = 1'b0;
        @(negedge clk_i);
        check("wr_busy_done", busy_o, 0);
        check("wr_rv_seen", rv_q.size(), 0);
        // hart2 withdraws before grant; rr_ptr must stay at 2
        cyc();
        master_req_i = 3'b100;
        cyc();
        @(negedge clk_i);
        check("wd_owner", owner_o, 2);
        check("wd_busy", busy_o, 1);
        cyc();
        master_req_i = '0;
        @(negedge clk_i);
        check("wd_gnt", master_gnt_o, 0);
        cyc();
        @(negedge clk_i);
        check("wd_idle", busy_o, 0);
        cyc();
        auto = 1'b1;
        master_req_i = 3'b111;
        gnt_q.push_back(2);
        gnt_q.push_back(0);
        push_rv(2, master_addr_i[95:64] ^ K, 1'b0);
        push_rv(0, master_addr_i[31:0] ^ K, 1'b0);
        wait_gnt();
        master_req_i = '0;
        wait_rv();
        auto = 1'b0;
        // timeout: hart0 granted, slave never answers
        master_req_i = 3'b001;
        man_gnt = 1'b1;
        gnt_q.push_back(0);
        cyc();
        cyc();
        master_req_i = '0;
        man_gnt = 1'b0;
        push_rv(0, 32'hDEAD_BEEF, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            check("to_rv_cycle", master_rvalid_o[0], 32'(k == 5));
        end
        @(negedge clk_i);
        check("to_pulse", timeout_o, 0);
        check("to_flush_busy", busy_o, 1);
        repeat (3) @(negedge clk_i);
        check("to_flush_hold", busy_o, 1);
        cyc();
        man_rvalid = 1'b1;
        man_rdata = 32'h5555_AAAA;
        @(negedge clk_i);
        check("to_flush_drop", master_rvalid_o, 0);
        cyc();
        man_rvalid = 1'b0;
        @(negedge clk_i);
        check("to_flush_idle", busy_o, 0);
        // slave rvalid coincides with the counter limit
        cyc();
        master_req_i = 3'b010;
        man_gnt = 1'b1;
        gnt_q.push_back(1);
        cyc();
        cyc();
        master_req_i = '0;
        man_gnt = 1'b0;
        push_rv(1, 32'hCAFE_0001, 1'b0);
        repeat (4) cyc();
        man_rvalid = 1'b1;
        man_rdata = 32'hCAFE_0001;
        @(negedge clk_i);
        check("co_to", timeout_o, 0);
        check("co_rv", master_rvalid_o, 3'b010);
        cyc();
        man_rvalid = 1'b0;
        @(negedge clk_i);
        check("co_idle", busy_o, 0);
        // reset while in RESP
        cyc();
        master_req_i = 3'b001;
        man_gnt = 1'b1;
        gnt_q.push_back(0);
        cyc();
        cyc();
        master_req_i = '0;
        man_gnt = 1'b0;
        rst_i = 1'b1;
        man_rvalid = 1'b1;
        man_rdata = 32'h7777_7777;
        @(negedge clk_i);
        check("mr_busy", busy_o, 0);
        check("mr_rv", master_rvalid_o, 0);
        check("mr_sreq", slave_req_o, 0);
        check("mr_owner", owner_o, 0);
        cyc();
        rst_i = 1'b0;
        man_rvalid = 1'b0;
        @(negedge clk_i);
        check("mr_idle", busy_o, 0);
        cyc();
        auto = 1'b1;
        master_req_i = 3'b011;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        push_rv(0, master_addr_i[31:0] ^ K, 1'b0);
        push_rv(1, master_addr_i[63:32] ^ K, 1'b0);
        wait_gnt();
        master_req_i = '0;
        wait_rv();
        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
